// File: rtl/mc_out_port_stage.sv
// mc_out_port_stage: per-output-port register stage behind dstMgmt in the bless_mc router.
// Captures the flit granted to OUTDIR, ages it, squashes copies with an empty destination
// list, and buffers up to two flits in a skid FIFO toward the link (valid/ready).
// Optional build macro: MC_OUT_STATS_EN enables the saturating stat_fwd/stat_squash counters;
// when undefined both stat outputs are tied to 0 and the port list is unchanged.

`ifndef NUM_PORT
`define NUM_PORT 5
`endif
`ifndef DST_LIST_WIDTH
`define DST_LIST_WIDTH 8
`endif

module mc_out_port_stage #(
    parameter int unsigned OUTDIR     = 0,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned AGE_WIDTH  = 8,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [`NUM_PORT-1:0]       alloc_pv,
    input  logic                       in_valid,
    input  logic [`DST_LIST_WIDTH-1:0] in_dst_list,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [AGE_WIDTH-1:0]       in_age,
    output logic                       port_busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [`DST_LIST_WIDTH-1:0] out_dst_list,
    output logic [AGE_WIDTH-1:0]       out_age,
    output logic                       overflow,
    output logic [STAT_WIDTH-1:0]      stat_fwd,
    output logic [STAT_WIDTH-1:0]      stat_squash
);

    localparam int unsigned DST_W = `DST_LIST_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [DST_W-1:0]      dst;
        logic [AGE_WIDTH-1:0]  age;
    } entry_t;

    entry_t         mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     count;
    logic [1:0]     count_nxt;

    logic           grant;
    logic           squash;
    logic           push;
    logic           pop;
    logic           push_ok;
    logic [AGE_WIDTH-1:0] age_inc;
    logic           unused_alloc;

    // Only bit OUTDIR of the allocation vector matters for this port.
    assign unused_alloc = ^alloc_pv;

    // Handshake decode: grant, squash of empty-destination copies, accept/pop.
    always_comb begin
        grant   = in_valid & alloc_pv[OUTDIR];
        squash  = grant & (in_dst_list == '0);
        push    = grant & ~squash;
        pop     = out_valid & out_ready;
        push_ok = push & ((count != 2'd2) | pop);
    end

    // Saturating age increment for the stored copy.
    always_comb begin
        age_inc = (in_age == '1) ? in_age : in_age + AGE_WIDTH'(1);
    end

    // Occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_nxt = count;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // FIFO storage, pointers, and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            out_valid <= 1'b0;
            port_busy <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= '{data: in_data, dst: in_dst_list, age: age_inc};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push & ~push_ok) begin
                overflow <= 1'b1;
            end
            count     <= count_nxt;
            out_valid <= (count_nxt != 2'd0);
            port_busy <= (count_nxt == 2'd2);
        end
    end

    // Head fields are read straight from the storage registers.
    assign out_data     = mem[rd_ptr].data;
    assign out_dst_list = mem[rd_ptr].dst;
    assign out_age      = mem[rd_ptr].age;

`ifdef MC_OUT_STATS_EN
    // Saturating forward/squash counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fwd    <= '0;
            stat_squash <= '0;
        end else begin
            if (pop && (stat_fwd != '1)) begin
                stat_fwd <= stat_fwd + STAT_WIDTH'(1);
            end
            if (squash && (stat_squash != '1)) begin
                stat_squash <= stat_squash + STAT_WIDTH'(1);
            end
        end
    end
`else
    assign stat_fwd    = '0;
    assign stat_squash = '0;
`endif

endmodule
